nios_simple_sysid_arb: RTL and testbench

NIOS_SIMPLE_SYSID_ARB -- requirements
Module: nios_simple_sysid_arb

---
 rtl/nios_simple_sysid_arb.sv | 94 +++++++++
 tb/tb_nios_simple_sysid_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_simple_sysid_arb.sv
// Two-master read arbiter in front of a combinational sysid slave: IDLE -> ACCESS -> RESP.
// Define NIOS_SIMPLE_SYSID_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module nios_simple_sysid_arb #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_read,
  input  logic              m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_address,
  input  logic [DATA_W-1:0] s_readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              addr_p0;
  logic              win_p0;
  logic [DATA_W-1:0] data_p1;
  logic              vld0_p1;
  logic              vld1_p1;
  logic              grant1;
  logic              accept;
`ifdef NIOS_SIMPLE_SYSID_ARB_RR_EN
  logic              last_grant;
`endif

  // Master 1 wins only when alone, or under round-robin when master 0 was served last.
  always_comb begin
    grant1 = 1'b0;
`ifdef NIOS_SIMPLE_SYSID_ARB_RR_EN
    grant1 = m1_read & (~m0_read | ~last_grant);
`else
    grant1 = m1_read & ~m0_read;
`endif
    accept = (state == IDLE) & (m0_read | m1_read) & ~reset;
  end

  assign m0_waitrequest   = ~(accept & ~grant1);
  assign m1_waitrequest   = ~(accept & grant1);
  assign s_address        = (state == ACCESS) & addr_p0;
  assign m0_readdatavalid = vld0_p1 & ~reset;
  assign m1_readdatavalid = vld1_p1 & ~reset;
  assign m0_readdata      = reset ? '0 : data_p1;
  assign m1_readdata      = reset ? '0 : data_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_p0 <= 1'b0;
      win_p0  <= 1'b0;
      data_p1 <= '0;
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
`ifdef NIOS_SIMPLE_SYSID_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
      case (state)
        // p0: command accepted, winner and address captured
        IDLE: begin
          if (accept) begin
            addr_p0 <= grant1 ? m1_address : m0_address;
            win_p0  <= grant1;
`ifdef NIOS_SIMPLE_SYSID_ARB_RR_EN
            last_grant <= grant1;
`endif
            state   <= ACCESS;
          end
        end
        // p1: slave data captured, response strobe prepared for the winner
        ACCESS: begin
          data_p1 <= s_readdata;
          vld0_p1 <= ~win_p0;
          vld1_p1 <= win_p0;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_simple_sysid_arb.sv
// Scoreboard bench for nios_simple_sysid_arb: driver pushes expected responses, monitor checks them.
module tb_nios_simple_sysid_arb;
  localparam logic [31:0] ID = 32'h6606C6D8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_read = 1'b0, m0_address = 1'b0;
  logic        m1_read = 1'b0, m1_address = 1'b0;
  logic        m0_waitrequest, m1_waitrequest;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        s_address;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { int m; logic [31:0] d; int c; } exp_t;
  exp_t q[$];

  nios_simple_sysid_arb #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_readdata(s_readdata)
  );

  assign s_readdata = s_address ? ID : 32'h0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Waits (bounded) for a mid-cycle sample showing a lowered waitrequest.
  task automatic wait_accept(output int m, output int c);
    m = -1;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!m0_waitrequest) begin m = 0; c = cyc; break; end
      if (!m1_waitrequest) begin m = 1; c = cyc; break; end
    end
    if (m < 0) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got none want accept (cycle %0d)", cyc);
    end
  endtask

  task automatic expect_accept(input string name, input int exp_m, input logic [31:0] exp_d,
                               output int c);
    int m;
    exp_t e;
    wait_accept(m, c);
    if (m >= 0) begin
      chk(name, m, exp_m);
      e.m = exp_m; e.d = exp_d; e.c = c;
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: responses, slave address and waitrequest after accept.
  logic [1:0] acc_hist = 2'b00;
  logic       acc_addr = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      chk("s_address", s_address, acc_hist[0] ? acc_addr : 1'b0);
      if (acc_hist != 2'b00) begin
        chk("wr_busy_m0", m0_waitrequest, 1'b1);
        chk("wr_busy_m1", m1_waitrequest, 1'b1);
      end
      chk("single_grant", !m0_waitrequest && !m1_waitrequest, 1'b0);
      chk("rd_match", m1_readdata, m0_readdata);
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (q.size() == 0) begin
          chk("unexpected_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
        end else begin
          e = q.pop_front();
          chk("rdv_who", {m1_readdatavalid, m0_readdatavalid}, e.m == 1 ? 2'b10 : 2'b01);
          chk("rdv_data", m0_readdata, e.d);
          chk("rdv_latency", cyc - e.c, 2);
        end
      end
    end
    acc_hist <= {acc_hist[0], !m0_waitrequest || !m1_waitrequest};
    acc_addr <= !m0_waitrequest ? m0_address : m1_address;
  end

  initial begin
    int c, c_prev, m;
    int order [4];
`ifdef NIOS_SIMPLE_SYSID_ARB_RR_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 0, 0, 0};
`endif
    step(); step();
    @(negedge clock);
    chk("rst_wr0", m0_waitrequest, 1'b1);
    chk("rst_wr1", m1_waitrequest, 1'b1);
    chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    chk("rst_data", m0_readdata, 32'h0);
    chk("rst_saddr", s_address, 1'b0);
    step();
    reset = 1'b0;

    // Both masters holding reads for four transactions
    m0_read = 1'b1; m0_address = 1'b1;
    m1_read = 1'b1; m1_address = 1'b0;
    for (int i = 0; i < 4; i++)
      expect_accept("both_grant", order[i], order[i] == 0 ? ID : 32'h0, c);
    step();
    m0_read = 1'b0; m1_read = 1'b0;
    step(); step(); step();

    // m0 alone at address 1
    m0_read = 1'b1; m0_address = 1'b1;
    expect_accept("m0_alone", 0, ID, c);
    step();
    m0_read = 1'b0;
    step(); step(); step();

    // m1 alone at address 0
    m1_read = 1'b1; m1_address = 1'b0;
    expect_accept("m1_alone", 1, 32'h0, c);
    step();
    m1_read = 1'b0;
    step(); step(); step();

    // m0 back-to-back with read held high
    m0_read = 1'b1; m0_address = 1'b1;
    expect_accept("b2b_0", 0, ID, c_prev);
    for (int i = 0; i < 2; i++) begin
      expect_accept("b2b_n", 0, ID, c);
      chk("b2b_spacing", c - c_prev, 3);
      c_prev = c;
    end
    step();
    m0_read = 1'b0;
    step(); step(); step();

    // m1 alone with m0 address 1 on m1 to leave m1 as last grant
    m1_read = 1'b1; m1_address = 1'b1;
    expect_accept("m1_addr1", 1, ID, c);
    step();
    m1_read = 1'b0;
    step(); step(); step();

    // Reset pulsed in the ACCESS cycle of an m0 read: no response expected
    m0_read = 1'b1; m0_address = 1'b1;
    wait_accept(m, c);
    chk("abort_acc", m, 0);
    step();
    m0_read = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("abort_wr0", m0_waitrequest, 1'b1);
    chk("abort_wr1", m1_waitrequest, 1'b1);
    chk("abort_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    chk("abort_data", m0_readdata, 32'h0);
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("abort_no_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    step(); step();

    // Simultaneous request after reset goes to m0
    m0_read = 1'b1; m0_address = 1'b0;
    m1_read = 1'b1; m1_address = 1'b1;
    expect_accept("post_rst_grant", 0, 32'h0, c);
    step();
    m0_read = 1'b0; m1_read = 1'b0;
    step(); step(); step();

    // Reset while idle
    reset = 1'b1;
    @(negedge clock);
    chk("idle_rst_wr0", m0_waitrequest, 1'b1);
    chk("idle_rst_wr1", m1_waitrequest, 1'b1);
    chk("idle_rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 2'b00);
    chk("idle_rst_saddr", s_address, 1'b0);
    step();
    reset = 1'b0;
    step(); step();

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
